fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the
//  hazard detection unit. Owns the PC and drives the instruction memory address.
//  Latches fetched instructions into IF/ID, and feeds the decoded source-register
//  fields back to the HDU. Obeys HDU enablePC (stall), branch redirect (flush) and
//  instruction-memory wait states (bubble insertion).
// PARAMETERS
//  ADDR_W     16  PC / instruction address width
//  INSTR_W    32  instruction width
//  RESET_PC   0   PC value loaded on reset
//  PC_INC     1   PC increment per fetched instruction (word-addressed)
//  RA_LSB     20  LSB of 4-bit source field A in instruction
//  RB_LSB     16  LSB of 4-bit source field B in instruction
//  NOP_INSTR  0   encoding written into IF/ID on bubble/flush
// PORTS
//  clock            in   1        rising-edge clock
//  reset            in   1        synchronous, active-high
//  enable_pc        in   1        from HDU enablePC; 0 = stall fetch and hold IF/ID
//  branch_taken     in   1        redirect request; flushes IF/ID
//  branch_target    in   ADDR_W   redirect address
//  imem_addr        out  ADDR_W   instruction memory address (= pc, combinational)
//  imem_data        in   INSTR_W  instruction word at imem_addr
//  imem_ready       in   1        1 = imem_data valid this cycle
//  if_id_instr      out  INSTR_W  IF/ID instruction
//  if_id_pc         out  ADDR_W   PC of if_id_instr
//  if_id_valid      out  1        1 = IF/ID holds a real instruction
//  if_id_registerA  out  4        if_id_instr[RA_LSB+3:RA_LSB], to HDU
//  if_id_registerB  out  4        if_id_instr[RB_LSB+3:RB_LSB], to HDU
// BEHAVIOUR
//  Reset (sync, active-high, highest priority): pc=RESET_PC, if_id_instr=NOP_INSTR,
//   if_id_pc=0, if_id_valid=0, state=BOOT; registerA/B follow instr (0 for NOP 0).
//  State machine: BOOT -> RUN after exactly one post-reset cycle. In BOOT, pc holds,
//   IF/ID holds bubble, branch_taken ignored. RUN is permanent until reset.
//  RUN, per rising edge, first matching rule wins:
//   1 branch_taken=1: pc<=branch_target; IF/ID<=bubble (instr=NOP_INSTR, valid=0).
//     Applies even when enable_pc=0 or imem_ready=0.
//   2 enable_pc=0: pc and all IF/ID registers hold (no bubble, no fetch).
//   3 imem_ready=0: pc holds; IF/ID<=bubble.
//   4 otherwise: if_id_instr<=imem_data, if_id_pc<=pc, if_id_valid<=1,
//     pc<=pc+PC_INC modulo 2^ADDR_W (wrap from all-ones, no flag).
//  Latency: word at address P appears on if_id_instr one edge after the edge on which
//   pc=P and rule 4 applies. Throughput 1 instr/cycle with no stall/wait/branch.
//  imem_addr = pc combinationally; constant while stalled or waiting.
//  Reset mid-stall/mid-wait: reset wins; no state survives.
//  Branch with branch_target==pc: pc unchanged, IF/ID still flushed.
// CONFIGURATION
//  FETCH_PERF_EN defined: add outputs fetch_count[31:0] (+1 per rule-4 edge) and
//   bubble_count[31:0] (+1 per rule-1 or rule-3 edge). Both reset to 0 and wrap at
//   2^32. Rule 2 and BOOT edges increment neither.
//  FETCH_PERF_EN undefined: counters and ports absent; all other behaviour is identical.
// TESTING
//  Reset 2 cycles, imem_ready=1, enable_pc=1, imem returns addr+0x100 -> BOOT 1 cycle;
//   then if_id_instr 0x100,0x101,0x102 on consecutive cycles with if_id_pc 0,1,2, valid=1.
//  enable_pc=0 for 3 cycles while pc=5 -> imem_addr stays 5; IF/ID frozen at pc 4 word;
//   resumes with pc 5 word on first edge after enable_pc=1.
//  imem_ready=0 for 2 cycles at pc=8 -> two bubbles (valid=0, instr=0), pc stays 8,
//   then word 8 latched.
//  branch_taken=1, target=0x40, same cycle enable_pc=0 -> next edge pc=0x40, valid=0;
//   word 0x40 latched on the following edge.
//  ADDR_W=4, pc=0xF, normal fetch -> pc wraps to 0x0, if_id_pc=0xF.
//  FETCH_PERF_EN: 10 fetches, 2 waits, 1 branch, 3 stalls -> fetch_count=10,
//   bubble_count=3.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: HDU control, instruction memory port and IF/ID outputs.
// Optional: FETCH_PERF_EN adds the fetch/bubble performance counters.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 32
);
  logic               enable_pc;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_ready;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               if_id_valid;
  logic [3:0]         if_id_registerA;
  logic [3:0]         if_id_registerB;
`ifdef FETCH_PERF_EN
  logic [31:0]        fetch_count;
  logic [31:0]        bubble_count;

  modport master (
    input  enable_pc, branch_taken, branch_target, imem_data, imem_ready,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid,
    output if_id_registerA, if_id_registerB, fetch_count, bubble_count
  );

  modport slave (
    output enable_pc, branch_taken, branch_target, imem_data, imem_ready,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid,
    input  if_id_registerA, if_id_registerB, fetch_count, bubble_count
  );
`else
  modport master (
    input  enable_pc, branch_taken, branch_target, imem_data, imem_ready,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid,
    output if_id_registerA, if_id_registerB
  );

  modport slave (
    output enable_pc, branch_taken, branch_target, imem_data, imem_ready,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid,
    input  if_id_registerA, if_id_registerB
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register with stall, branch flush and imem wait bubbles.
// Optional: define FETCH_PERF_EN to add fetch_count / bubble_count counters.
module fetch_stage #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int unsigned        PC_INC    = 1,
  parameter int unsigned        RA_LSB    = 20,
  parameter int unsigned        RB_LSB    = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master bus
);

  typedef enum logic {
    S_BOOT,
    S_RUN
  } state_e;

  // What the pipeline does on the coming edge; priority is resolved once here.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FETCH
  } action_e;

  state_e             state_q;
  action_e            action;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_inc_d;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  if_pc_q;
  logic               valid_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    action = ACT_IDLE;
    if (state_q == S_RUN) begin
      if (bus.branch_taken)     action = ACT_FLUSH;
      else if (!bus.enable_pc)  action = ACT_HOLD;
      else if (!bus.imem_ready) action = ACT_BUBBLE;
      else                      action = ACT_FETCH;
    end
  end

  assign pc_inc_d = pc_q + ADDR_W'(PC_INC);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      if_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= S_RUN;
      case (action)
        ACT_FLUSH: begin
          pc_q    <= bus.branch_target;
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
        ACT_BUBBLE: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
        ACT_FETCH: begin
          pc_q    <= pc_inc_d;
          instr_q <= bus.imem_data;
          if_pc_q <= pc_q;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] bubble_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (action == ACT_FETCH)
        fetch_count_q <= fetch_count_q + 32'd1;
      if (action == ACT_FLUSH || action == ACT_BUBBLE)
        bubble_count_q <= bubble_count_q + 32'd1;
    end
  end

  assign bus.fetch_count  = fetch_count_q;
  assign bus.bubble_count = bubble_count_q;
`endif

  assign bus.imem_addr       = pc_q;
  assign bus.if_id_instr     = instr_q;
  assign bus.if_id_pc        = if_pc_q;
  assign bus.if_id_valid     = valid_q;
  assign bus.if_id_registerA = instr_q[RA_LSB +: 4];
  assign bus.if_id_registerB = instr_q[RB_LSB +: 4];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, streaming, stall, wait, branch, field decode, wrap.
// Define FETCH_PERF_EN to also exercise the performance counters.
module tb_fetch_stage;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_stage_if #(.ADDR_W(16), .INSTR_W(32)) bus ();
  fetch_stage_if #(.ADDR_W(4),  .INSTR_W(32)) bus4 ();

  logic        use_custom;
  logic [31:0] custom_word;

  // Instruction memory model: word at address A is A + 0x100 unless overridden.
  assign bus.imem_data  = use_custom ? custom_word : 32'(bus.imem_addr) + 32'h100;
  assign bus4.imem_data = 32'(bus4.imem_addr) + 32'h100;

  fetch_stage #(.ADDR_W(16), .INSTR_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  fetch_stage #(.ADDR_W(4), .INSTR_W(32)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  int checks = 0;
  int errors = 0;

  // Observed {valid, if_id_pc, if_id_instr, imem_addr} of the 16-bit instance.
  function automatic logic [64:0] obs();
    return {bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.imem_addr};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [64:0] exp;
    reset = 1'b1;
    bus.enable_pc = 1'b1; bus.imem_ready = 1'b1;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus4.enable_pc = 1'b1; bus4.imem_ready = 1'b1;
    bus4.branch_taken = 1'b0; bus4.branch_target = '0;
    use_custom = 1'b0; custom_word = '0;
    step(2);
    exp = {1'b0, 16'h0, 32'h0, 16'h0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs(), exp);
    end
    checks++;
    if ({bus.if_id_registerA, bus.if_id_registerB} !== 8'h00) begin
      errors++; $display("FAIL reset_regs got %h exp 00", {bus.if_id_registerA, bus.if_id_registerB});
    end
    reset = 1'b0;
    step(1);
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL boot_hold got %h exp %h", obs(), exp);
    end
  endtask

  task automatic test_stream();
    logic [64:0] exp;
    for (int i = 0; i < 5; i++) begin
      step(1);
      exp = {1'b1, 16'(i), 32'h100 + 32'(i), 16'(i + 1)};
      checks++;
      if (obs() !== exp) begin
        errors++; $display("FAIL stream_%0d got %h exp %h", i, obs(), exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [64:0] exp;
    bus.enable_pc = 1'b0;
    exp = {1'b1, 16'h4, 32'h104, 16'h5};
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (obs() !== exp) begin
        errors++; $display("FAIL stall_%0d got %h exp %h", i, obs(), exp);
      end
    end
    bus.enable_pc = 1'b1;
    step(1);
    exp = {1'b1, 16'h5, 32'h105, 16'h6};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL stall_resume got %h exp %h", obs(), exp);
    end
  endtask

  task automatic test_wait();
    logic [64:0] exp;
    step(2);
    bus.imem_ready = 1'b0;
    exp = {1'b0, 16'h7, 32'h0, 16'h8};
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++;
      if (obs() !== exp) begin
        errors++; $display("FAIL wait_%0d got %h exp %h", i, obs(), exp);
      end
    end
    bus.imem_ready = 1'b1;
    step(1);
    exp = {1'b1, 16'h8, 32'h108, 16'h9};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL wait_resume got %h exp %h", obs(), exp);
    end
  endtask

  task automatic test_branch();
    logic [64:0] exp;
    bus.branch_taken = 1'b1; bus.branch_target = 16'h40; bus.enable_pc = 1'b0;
    step(1);
    exp = {1'b0, 16'h8, 32'h0, 16'h40};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL branch_stall got %h exp %h", obs(), exp);
    end
    bus.branch_taken = 1'b0; bus.enable_pc = 1'b1;
    step(1);
    exp = {1'b1, 16'h40, 32'h140, 16'h41};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL branch_land got %h exp %h", obs(), exp);
    end
    bus.branch_taken = 1'b1; bus.branch_target = 16'h41; bus.imem_ready = 1'b0;
    step(1);
    exp = {1'b0, 16'h40, 32'h0, 16'h41};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL branch_self got %h exp %h", obs(), exp);
    end
    bus.branch_taken = 1'b0; bus.imem_ready = 1'b1;
    step(1);
    exp = {1'b1, 16'h41, 32'h141, 16'h42};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL branch_self_land got %h exp %h", obs(), exp);
    end
  endtask

  task automatic test_fields();
    use_custom = 1'b1; custom_word = 32'h00A5_0000;
    step(1);
    checks++;
    if ({bus.if_id_registerA, bus.if_id_registerB, bus.if_id_instr} !== {4'hA, 4'h5, 32'h00A5_0000}) begin
      errors++; $display("FAIL fields got %h %h %h exp a 5 00a50000",
                         bus.if_id_registerA, bus.if_id_registerB, bus.if_id_instr);
    end
    use_custom = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    logic [64:0] exp;
    bus.enable_pc = 1'b0; bus.imem_ready = 1'b0; reset = 1'b1;
    step(1);
    exp = {1'b0, 16'h0, 32'h0, 16'h0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL reset_mid_stall got %h exp %h", obs(), exp);
    end
    reset = 1'b0; bus.enable_pc = 1'b1; bus.imem_ready = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_target = 16'h77;
    step(1);
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL boot_ignores_branch got %h exp %h", obs(), exp);
    end
    bus.branch_taken = 1'b0;
    step(1);
    exp = {1'b1, 16'h0, 32'h100, 16'h1};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL post_reset_fetch got %h exp %h", obs(), exp);
    end
  endtask

  task automatic test_wrap();
    bus4.branch_taken = 1'b1; bus4.branch_target = 4'hF;
    step(1);
    checks++;
    if ({bus4.imem_addr, bus4.if_id_valid} !== {4'hF, 1'b0}) begin
      errors++; $display("FAIL wrap_redirect got %h/%b exp f/0", bus4.imem_addr, bus4.if_id_valid);
    end
    bus4.branch_taken = 1'b0;
    step(1);
    checks++;
    if ({bus4.imem_addr, bus4.if_id_pc, bus4.if_id_instr, bus4.if_id_valid} !== {4'h0, 4'hF, 32'h10F, 1'b1}) begin
      errors++; $display("FAIL wrap got addr=%h pc=%h instr=%h v=%b exp 0 f 0000010f 1",
                         bus4.imem_addr, bus4.if_id_pc, bus4.if_id_instr, bus4.if_id_valid);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    bus.enable_pc = 1'b1; bus.imem_ready = 1'b1; bus.branch_taken = 1'b0;
    step(2);
    checks++;
    if ({bus.fetch_count, bus.bubble_count} !== 64'h0) begin
      errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", bus.fetch_count, bus.bubble_count);
    end
    reset = 1'b0;
    step(1);
    step(5);
    bus.imem_ready = 1'b0;
    step(2);
    bus.imem_ready = 1'b1; bus.enable_pc = 1'b0;
    step(3);
    bus.enable_pc = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h20;
    step(1);
    bus.branch_taken = 1'b0;
    step(5);
    checks++;
    if (bus.fetch_count !== 32'd10) begin
      errors++; $display("FAIL perf_fetch got %0d exp 10", bus.fetch_count);
    end
    checks++;
    if (bus.bubble_count !== 32'd3) begin
      errors++; $display("FAIL perf_bubble got %0d exp 3", bus.bubble_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_wait();
    test_branch();
    test_fields();
    test_reset_mid_stall();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
